mp_regfile_sb: RTL and testbench

MP_REGFILE_SB -- requirements
Module: mp_regfile_sb

---
 rtl/mp_regfile_sb_pkg.sv | 23 ++
 rtl/mp_regfile_sb_if.sv | 44 ++++
 rtl/mp_regfile_sb_scoreboard.sv | 98 +++++++++
 rtl/mp_regfile_sb.sv | 91 +++++++++
 tb/tb_mp_regfile_sb.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp_regfile_sb_pkg.sv
// Shared definitions for the multi-port register file with scoreboard:
// default widths, the age-tag type and the wrap-around age comparison.
package rf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAGW  = 6;

  typedef logic [DEF_TAGW-1:0] tag_t;

  // Tag a is younger than tag b when (a - b) mod 2^tagw falls in
  // [1, 2^(tagw-1)). Tags are passed zero-extended to 32 bits so the
  // same function serves every tag width.
  function automatic logic is_younger(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input int          tagw);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (tagw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << tagw) - 32'd1);
    diff = (a - b) & mask;
    return (diff != 32'd0) && (diff < (32'd1 << (tagw - 1)));
  endfunction

endpackage

// File: rtl/mp_regfile_sb_if.sv
// Bundle of the read, issue and writeback ports of the register file.
// The master side drives addresses, issues and writebacks; the slave
// side is the register file itself.
interface mp_regfile_sb_if
  import rf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = 32,
  parameter int NRD   = 4,
  parameter int NWR   = 2,
  parameter int NISS  = 2,
  parameter int TAGW  = DEF_TAGW
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [NRD-1:0][AW-1:0]     rd_addr;
  logic [NRD-1:0][WIDTH-1:0]  rd_data;
  logic [NRD-1:0]             rd_busy;

  logic [NISS-1:0]            iss_valid;
  logic [NISS-1:0][AW-1:0]    iss_rd;
  logic [NISS-1:0][TAGW-1:0]  iss_tag;

  logic [NWR-1:0]             wb_valid;
  logic [NWR-1:0][AW-1:0]     wb_rd;
  logic [NWR-1:0][WIDTH-1:0]  wb_data;
  logic [NWR-1:0][TAGW-1:0]   wb_tag;

  logic                       stale_drop;

  modport master (
    output rd_addr, iss_valid, iss_rd, iss_tag,
           wb_valid, wb_rd, wb_data, wb_tag,
    input  rd_data, rd_busy, stale_drop
  );

  modport slave (
    input  rd_addr, iss_valid, iss_rd, iss_tag,
           wb_valid, wb_rd, wb_data, wb_tag,
    output rd_data, rd_busy, stale_drop
  );

endinterface

// File: rtl/mp_regfile_sb_scoreboard.sv
// Busy/owner tracking for every architectural register. Decides which
// writebacks are accepted (target busy and tag matches owner), resolves
// same-cycle issue collisions by age, and flags discarded writebacks.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NWR  = 2,
  parameter int NISS = 2,
  parameter int TAGW = DEF_TAGW,
  parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NISS-1:0]           iss_valid,
  input  logic [NISS-1:0][AW-1:0]   iss_rd,
  input  logic [NISS-1:0][TAGW-1:0] iss_tag,
  input  logic [NWR-1:0]            wb_valid,
  input  logic [NWR-1:0][AW-1:0]    wb_rd,
  input  logic [NWR-1:0][TAGW-1:0]  wb_tag,
  output logic [NREG-1:0]           busy,
  output logic [NWR-1:0]            wb_accept,
  output logic                      stale_drop
);

  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           busy_d;
  logic [NREG-1:0][TAGW-1:0] owner_q;
  logic [NREG-1:0][TAGW-1:0] owner_d;
  logic [NWR-1:0]            wb_hit;
  logic [NREG-1:0]           clr;
  logic [NREG-1:0]           iss_hit;
  logic [NREG-1:0][TAGW-1:0] win;
  logic                      drop_d;

  assign busy = busy_q;

  // Match each writeback against its target's owner; register 0 and
  // out-of-range indices never hit, so they are ignored silently.
  always_comb begin
    wb_accept = '0;
    wb_hit    = '0;
    for (int w = 0; w < NWR; w++) begin
      for (int r = 1; r < NREG; r++) begin
        if (wb_rd[w] == AW'(r)) begin
          wb_hit[w] = 1'b1;
          if (wb_valid[w] && busy_q[r] && (owner_q[r] == wb_tag[w]))
            wb_accept[w] = 1'b1;
        end
      end
    end
  end

  assign drop_d = |(wb_valid & wb_hit & ~wb_accept);

  // Next busy/owner state: an issue wins over a same-cycle clear, and the
  // youngest of several same-cycle issues to one register becomes owner.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    clr     = '0;
    iss_hit = '0;
    win     = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int w = 0; w < NWR; w++) begin
        if (wb_accept[w] && (wb_rd[w] == AW'(r)))
          clr[r] = 1'b1;
      end
      for (int i = 0; i < NISS; i++) begin
        if (iss_valid[i] && (iss_rd[i] == AW'(r))) begin
          if (!iss_hit[r] || is_younger(32'(iss_tag[i]), 32'(win[r]), TAGW))
            win[r] = iss_tag[i];
          iss_hit[r] = 1'b1;
        end
      end
      if (iss_hit[r]) begin
        busy_d[r]  = 1'b1;
        owner_d[r] = win[r];
      end else if (clr[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // Scoreboard state and the registered stale-drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      owner_q    <= '0;
      stale_drop <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      stale_drop <= drop_d;
    end
  end

endmodule

// File: rtl/mp_regfile_sb.sv
// Multi-port register file with a tag-based scoreboard. Holds the data
// array and the zero-latency bypass from accepted writebacks to reads;
// busy/owner bookkeeping lives in rf_scoreboard.
module mp_regfile_sb
  import rf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = 32,
  parameter int NRD   = 4,
  parameter int NWR   = 2,
  parameter int NISS  = 2,
  parameter int TAGW  = DEF_TAGW
) (
  input logic            clk,
  input logic            rst,
  mp_regfile_sb_if.slave bus
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [NREG-1:0][WIDTH-1:0] data_q;
  logic [NREG-1:0][WIDTH-1:0] data_d;
  logic [NREG-1:0]            busy;
  logic [NWR-1:0]             wb_accept;
  logic [NRD-1:0][WIDTH-1:0]  rd_data_c;
  logic [NRD-1:0]             rd_busy_c;

  rf_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .NISS (NISS),
    .TAGW (TAGW),
    .AW   (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (bus.iss_valid),
    .iss_rd     (bus.iss_rd),
    .iss_tag    (bus.iss_tag),
    .wb_valid   (bus.wb_valid),
    .wb_rd      (bus.wb_rd),
    .wb_tag     (bus.wb_tag),
    .busy       (busy),
    .wb_accept  (wb_accept),
    .stale_drop (bus.stale_drop)
  );

  // Accepted writebacks update the data array; register 0 is never written.
  always_comb begin
    data_d = data_q;
    for (int r = 1; r < NREG; r++) begin
      for (int w = 0; w < NWR; w++) begin
        if (wb_accept[w] && (bus.wb_rd[w] == AW'(r)))
          data_d[r] = bus.wb_data[w];
      end
    end
  end

  // Data array storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_q <= '0;
    else
      data_q <= data_d;
  end

  // Combinational read with bypass: an accepted writeback to the same
  // register supplies the data and hides the busy bit this cycle.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int r = 1; r < NREG; r++) begin
        if (bus.rd_addr[p] == AW'(r)) begin
          rd_data_c[p] = data_q[r];
          rd_busy_c[p] = busy[r];
          for (int w = 0; w < NWR; w++) begin
            if (wb_accept[w] && (bus.wb_rd[w] == AW'(r))) begin
              rd_data_c[p] = bus.wb_data[w];
              rd_busy_c[p] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Directed self-checking bench for mp_regfile_sb with default parameters.
module tb_mp_regfile_sb;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int NISS  = 2;
  localparam int TAGW  = 6;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mp_regfile_sb_if #(
    .WIDTH(WIDTH), .NREG(NREG), .NRD(NRD), .NWR(NWR), .NISS(NISS), .TAGW(TAGW)
  ) bus ();

  mp_regfile_sb #(
    .WIDTH(WIDTH), .NREG(NREG), .NRD(NRD), .NWR(NWR), .NISS(NISS), .TAGW(TAGW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.iss_valid = '0;
    bus.iss_rd    = '0;
    bus.iss_tag   = '0;
    bus.wb_valid  = '0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.wb_tag    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.rd_addr = '0;
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd31;
    #2;
    checks++;
    if (bus.rd_data !== '0) begin
      errors++; $display("[TB] FAIL reset_rd_data: got %h expected 0", bus.rd_data);
    end
    checks++;
    if (bus.rd_busy !== '0) begin
      errors++; $display("[TB] FAIL reset_rd_busy: got %b expected 0", bus.rd_busy);
    end
    checks++;
    if (bus.stale_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stale: got %b expected 0", bus.stale_drop);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_issue_wb();
    bus.rd_addr[0] = 5'd5;
    bus.iss_valid[0] = 1'b1; bus.iss_rd[0] = 5'd5; bus.iss_tag[0] = 6'd3;
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL x5_issue_same_cycle_busy: got %b expected 0", bus.rd_busy[0]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL x5_busy_after_issue: got %b expected 1", bus.rd_busy[0]);
    end
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd5; bus.wb_tag[0] = 6'd3; bus.wb_data[0] = 32'hA5A5;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'hA5A5) begin
      errors++; $display("[TB] FAIL x5_bypass_data: got %h expected %h", bus.rd_data[0], 32'hA5A5);
    end
    checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL x5_bypass_busy: got %b expected 0", bus.rd_busy[0]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'hA5A5 || bus.rd_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL x5_stored: got %h/%b expected %h/0", bus.rd_data[0], bus.rd_busy[0], 32'hA5A5);
    end
    checks++;
    if (bus.stale_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL x5_no_stale: got %b expected 0", bus.stale_drop);
    end
  endtask

  task automatic test_stale_wb();
    bus.rd_addr[0] = 5'd7;
    bus.iss_valid[0] = 1'b1; bus.iss_rd[0] = 5'd7; bus.iss_tag[0] = 6'd4;
    tick();
    bus.iss_tag[0] = 6'd6;
    tick();
    clear_inputs();
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd7; bus.wb_tag[0] = 6'd4; bus.wb_data[0] = 32'h11;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL x7_stale_no_bypass: got %h/%b expected 0/1", bus.rd_data[0], bus.rd_busy[0]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.stale_drop !== 1'b1) begin
      errors++; $display("[TB] FAIL x7_stale_drop: got %b expected 1", bus.stale_drop);
    end
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL x7_still_busy: got %h/%b expected 0/1", bus.rd_data[0], bus.rd_busy[0]);
    end
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd7; bus.wb_tag[0] = 6'd6; bus.wb_data[0] = 32'h22;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h22 || bus.rd_busy[0] !== 1'b0 || bus.stale_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL x7_owner_wb: got %h/%b/%b expected 22/0/0", bus.rd_data[0], bus.rd_busy[0], bus.stale_drop);
    end
  endtask

  task automatic test_dual_issue();
    // Wrapped tags: 1 is younger than 62
    bus.rd_addr[0] = 5'd9;
    bus.iss_valid = 2'b11;
    bus.iss_rd[0] = 5'd9; bus.iss_tag[0] = 6'd62;
    bus.iss_rd[1] = 5'd9; bus.iss_tag[1] = 6'd1;
    tick();
    clear_inputs();
    bus.wb_valid[1] = 1'b1; bus.wb_rd[1] = 5'd9; bus.wb_tag[1] = 6'd62; bus.wb_data[1] = 32'h77;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL x9_old_tag_no_bypass: got %h/%b expected 0/1", bus.rd_data[0], bus.rd_busy[0]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.stale_drop !== 1'b1) begin
      errors++; $display("[TB] FAIL x9_old_tag_dropped: got %b expected 1", bus.stale_drop);
    end
    bus.wb_valid[1] = 1'b1; bus.wb_rd[1] = 5'd9; bus.wb_tag[1] = 6'd1; bus.wb_data[1] = 32'h88;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h88 || bus.rd_busy[0] !== 1'b0 || bus.stale_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL x9_wrapped_owner: got %h/%b/%b expected 88/0/0", bus.rd_data[0], bus.rd_busy[0], bus.stale_drop);
    end
    // Plain order: 30 is younger than 20, youngest on port 0
    bus.rd_addr[1] = 5'd10;
    bus.iss_valid = 2'b11;
    bus.iss_rd[0] = 5'd10; bus.iss_tag[0] = 6'd30;
    bus.iss_rd[1] = 5'd10; bus.iss_tag[1] = 6'd20;
    tick();
    clear_inputs();
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd10; bus.wb_tag[0] = 6'd20; bus.wb_data[0] = 32'h1010;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.stale_drop !== 1'b1 || bus.rd_busy[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL x10_older_dropped: got stale %b busy %b expected 1/1", bus.stale_drop, bus.rd_busy[1]);
    end
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd10; bus.wb_tag[0] = 6'd30; bus.wb_data[0] = 32'h3030;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[1] !== 32'h3030 || bus.rd_busy[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL x10_younger_owner: got %h/%b expected 3030/0", bus.rd_data[1], bus.rd_busy[1]);
    end
  endtask

  task automatic test_issue_and_wb();
    bus.rd_addr[0] = 5'd4;
    bus.iss_valid[0] = 1'b1; bus.iss_rd[0] = 5'd4; bus.iss_tag[0] = 6'd2;
    tick();
    clear_inputs();
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd4; bus.wb_tag[0] = 6'd2; bus.wb_data[0] = 32'h33;
    bus.iss_valid[1] = 1'b1; bus.iss_rd[1] = 5'd4; bus.iss_tag[1] = 6'd5;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h33 || bus.rd_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL x4_same_cycle_bypass: got %h/%b expected 33/0", bus.rd_data[0], bus.rd_busy[0]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h33 || bus.rd_busy[0] !== 1'b1 || bus.stale_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL x4_issue_overrides_clear: got %h/%b/%b expected 33/1/0", bus.rd_data[0], bus.rd_busy[0], bus.stale_drop);
    end
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd4; bus.wb_tag[0] = 6'd2; bus.wb_data[0] = 32'h44;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.stale_drop !== 1'b1 || bus.rd_data[0] !== 32'h33) begin
      errors++; $display("[TB] FAIL x4_old_owner_dropped: got stale %b data %h expected 1/33", bus.stale_drop, bus.rd_data[0]);
    end
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd4; bus.wb_tag[0] = 6'd5; bus.wb_data[0] = 32'h55;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h55 || bus.rd_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL x4_new_owner_wb: got %h/%b expected 55/0", bus.rd_data[0], bus.rd_busy[0]);
    end
  endtask

  task automatic test_x0();
    bus.rd_addr[1] = 5'd0;
    bus.iss_valid[0] = 1'b1; bus.iss_rd[0] = 5'd0; bus.iss_tag[0] = 6'd7;
    bus.wb_valid[1] = 1'b1; bus.wb_rd[1] = 5'd0; bus.wb_tag[1] = 6'd7; bus.wb_data[1] = 32'hFFFF;
    #1;
    checks++;
    if (bus.rd_data[1] !== 32'h0 || bus.rd_busy[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL x0_same_cycle: got %h/%b expected 0/0", bus.rd_data[1], bus.rd_busy[1]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[1] !== 32'h0 || bus.rd_busy[1] !== 1'b0 || bus.stale_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL x0_after: got %h/%b/%b expected 0/0/0", bus.rd_data[1], bus.rd_busy[1], bus.stale_drop);
    end
  endtask

  task automatic test_back_to_back();
    bus.rd_addr[2] = 5'd12;
    bus.rd_addr[3] = 5'd13;
    bus.iss_valid = 2'b11;
    bus.iss_rd[0] = 5'd12; bus.iss_tag[0] = 6'd10;
    bus.iss_rd[1] = 5'd13; bus.iss_tag[1] = 6'd11;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_busy[3:2] !== 2'b11) begin
      errors++; $display("[TB] FAIL dual_issue_busy: got %b expected 11", bus.rd_busy[3:2]);
    end
    bus.wb_valid = 2'b11;
    bus.wb_rd[0] = 5'd12; bus.wb_tag[0] = 6'd10; bus.wb_data[0] = 32'h1212;
    bus.wb_rd[1] = 5'd13; bus.wb_tag[1] = 6'd11; bus.wb_data[1] = 32'h1313;
    #1;
    checks++;
    if (bus.rd_data[2] !== 32'h1212 || bus.rd_data[3] !== 32'h1313) begin
      errors++; $display("[TB] FAIL dual_wb_bypass: got %h %h expected 1212 1313", bus.rd_data[2], bus.rd_data[3]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[2] !== 32'h1212 || bus.rd_data[3] !== 32'h1313 || bus.rd_busy[3:2] !== 2'b00) begin
      errors++; $display("[TB] FAIL dual_wb_stored: got %h %h %b expected 1212 1313 00", bus.rd_data[2], bus.rd_data[3], bus.rd_busy[3:2]);
    end
    // Writeback to a register that was never reserved is stale
    bus.rd_addr[2] = 5'd20;
    bus.wb_valid[1] = 1'b1; bus.wb_rd[1] = 5'd20; bus.wb_tag[1] = 6'd0; bus.wb_data[1] = 32'hDEAD;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.stale_drop !== 1'b1 || bus.rd_data[2] !== 32'h0) begin
      errors++; $display("[TB] FAIL idle_target_dropped: got stale %b data %h expected 1/0", bus.stale_drop, bus.rd_data[2]);
    end
  endtask

  task automatic test_async_reset();
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd15;
    bus.rd_addr[2] = 5'd7;
    bus.rd_addr[3] = 5'd4;
    bus.iss_valid[0] = 1'b1; bus.iss_rd[0] = 5'd15; bus.iss_tag[0] = 6'd1;
    tick();
    clear_inputs();
    bus.wb_valid[0] = 1'b1; bus.wb_rd[0] = 5'd15; bus.wb_tag[0] = 6'd9;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'hA5A5 || bus.rd_busy[1] !== 1'b1 || bus.stale_drop !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_state: got %h/%b/%b expected a5a5/1/1", bus.rd_data[0], bus.rd_busy[1], bus.stale_drop);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rd_data !== '0 || bus.rd_busy !== '0) begin
      errors++; $display("[TB] FAIL midrun_reset_reads: got %h %b expected 0 0", bus.rd_data, bus.rd_busy);
    end
    checks++;
    if (bus.stale_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_reset_stale: got %b expected 0", bus.stale_drop);
    end
    bus.iss_valid[0] = 1'b1; bus.iss_rd[0] = 5'd15; bus.iss_tag[0] = 6'd2;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rd_busy[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL issue_during_reset: got %b expected 0", bus.rd_busy[1]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.rd_busy[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL first_edge_after_reset: got %b expected 1", bus.rd_busy[1]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_issue_wb();
    test_stale_wb();
    test_dual_issue();
    test_issue_and_wb();
    test_x0();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
